rf_write_queue: RTL and testbench

- Writer-side front end for the 3-port register file (2 read ports, 1 write port).
- Accepts writeback results from the pipeline through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per granted cycle onto the single register-file write port.
- Provides a combinational bypass lookup so decode-stage reads see pending, not-yet-committed writes.

---
 rtl/rf_write_queue.sv | 161 ++++++++++++++++
 tb/tb_rf_write_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// ============================================================================
// rf_write_queue
// ----------------------------------------------------------------------------
// Writer-side front end for the 3-port register file (2 read, 1 write).
// Writeback results arrive over a valid/ready handshake. They are buffered in
// an in-order FIFO of DEPTH entries and drained one entry per granted cycle
// onto the single registered write port. A combinational bypass lookup lets
// decode-stage reads see writes that are queued but not yet committed.
//
// Optional feature (compile-time macro RF_WRITE_QUEUE_COALESCE_EN):
//   When defined, an accepted write to the same register as the youngest
//   queued entry overwrites that entry's data instead of allocating a new
//   one. This is allowed even when the queue is full. The exception is when
//   the youngest entry is also the head being popped on the same edge.
//   When undefined, every nonzero accept allocates a new entry.
//
// Parameters
//   DEPTH : number of queue entries (power of 2, >= 2)
//   AW    : register address width
//   DW    : data width
//
// Ports
//   clk, rst_n         : clock; asynchronous active-low reset
//   in_valid/in_ready  : writeback handshake
//   in_addr/in_data    : destination register and result value
//   rf_grant           : write port is available to the queue this cycle
//   rf_we/rf_wa/rf_wd  : registered register-file write port
//   q_ra1/q_ra2        : bypass lookup addresses for read ports 1 and 2
//   hit1/hit2          : a pending write to q_raX exists in the queue
//   hd1/hd2            : data of the newest pending write to q_raX (0 if none)
//   count              : number of occupied entries
// ============================================================================
module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       rf_grant,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_wa,
    output logic [DW-1:0]              rf_wd,
    input  logic [AW-1:0]              q_ra1,
    input  logic [AW-1:0]              q_ra2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DW-1:0]              hd1,
    output logic [DW-1:0]              hd2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_prev;

    logic          pop;
    logic          push;
    logic          coal_match;
    logic          coal_wr;

    assign tail_prev = tail - 1'b1;
    assign pop       = (count != '0) && rf_grant;

`ifdef RF_WRITE_QUEUE_COALESCE_EN
    // Merge into the youngest entry unless that entry leaves the queue on
    // this same edge (single entry being popped); then allocate normally.
    assign coal_match = (in_addr != '0) && (count != '0) &&
                        (addr_q[tail_prev] == in_addr) &&
                        !(pop && (count == CW'(1)));
`else
    assign coal_match = 1'b0;
`endif

    // in_ready ignores a simultaneous pop: a full queue never passes through.
    assign in_ready = (count < CW'(DEPTH)) || coal_match;
    assign coal_wr  = in_valid && coal_match;
    // Writes to register 0 are handshaked but dropped.
    assign push     = in_valid && in_ready && (in_addr != '0) && !coal_match;

    // Queue control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; validity is tracked by head/count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end else if (coal_wr) begin
            data_q[tail_prev] <= in_data;
        end
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (pop) begin
            rf_we <= 1'b1;
            rf_wa <= addr_q[head];
            rf_wd <= data_q[head];
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Bypass lookup. Scans from head (oldest) to tail so the youngest match
    // wins. A popped entry is already gone from the queue and an entry being
    // accepted is not yet in it, so both are excluded naturally.
    always_comb begin
        logic [PW-1:0] idx;
        idx  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        hd1  = '0;
        hd2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if ((q_ra1 != '0) && (addr_q[idx] == q_ra1)) begin
                    hit1 = 1'b1;
                    hd1  = data_q[idx];
                end
                if ((q_ra2 != '0) && (addr_q[idx] == q_ra2)) begin
                    hit2 = 1'b1;
                    hd2  = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;

`ifdef RF_WRITE_QUEUE_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        rf_grant;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  q_ra1;
    logic [4:0]  q_ra2;
    logic        hit1;
    logic        hit2;
    logic [31:0] hd1;
    logic [31:0] hd2;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    rf_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_grant (rf_grant),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .q_ra1    (q_ra1),
        .q_ra2    (q_ra2),
        .hit1     (hit1),
        .hit2     (hit2),
        .hd1      (hd1),
        .hd2      (hd2),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] id;
        logic        g;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  cnt;
        logic        rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ia, input logic [31:0] id,
                         input logic g, input logic [4:0] r1, input logic [4:0] r2);
        in_valid = iv;
        in_addr  = ia;
        in_data  = id;
        rf_grant = g;
        q_ra1    = r1;
        q_ra2    = r2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table rows: iv ia id g r1 r2 | cnt rdy we wa wd h1 d1 h2 d2
        // Basic accept/bypass/pop with 1-cycle latency
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 1, 5, 0,  1, 1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 0};
        tbl[1]  = '{0, 5, 32'h0,        1, 5, 0,  0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,        1, 5, 0,  0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0};
        // Fill with grant low, rejected fifth push, then drain in order
        tbl[3]  = '{1, 1, 32'h11,       0, 3, 4,  1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[4]  = '{1, 2, 32'h22,       0, 3, 4,  2, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[5]  = '{1, 3, 32'h33,       0, 3, 4,  3, 1, 0, 5, 32'hDEADBEEF, 1, 32'h33, 0, 0};
        tbl[6]  = '{1, 4, 32'h44,       0, 3, 4,  4, COAL, 0, 5, 32'hDEADBEEF, 1, 32'h33, 1, 32'h44};
        tbl[7]  = '{1, 9, 32'h99,       0, 3, 4,  4, 0, 0, 5, 32'hDEADBEEF, 1, 32'h33, 1, 32'h44};
        tbl[8]  = '{0, 0, 32'h0,        1, 3, 4,  3, 1, 1, 1, 32'h11,       1, 32'h33, 1, 32'h44};
        tbl[9]  = '{0, 0, 32'h0,        1, 3, 4,  2, 1, 1, 2, 32'h22,       1, 32'h33, 1, 32'h44};
        tbl[10] = '{0, 0, 32'h0,        1, 3, 4,  1, 1, 1, 3, 32'h33,       0, 0, 1, 32'h44};
        tbl[11] = '{0, 0, 32'h0,        1, 3, 4,  0, 1, 1, 4, 32'h44,       0, 0, 0, 0};
        tbl[12] = '{0, 0, 32'h0,        1, 3, 4,  0, 1, 0, 4, 32'h44,       0, 0, 0, 0};
        // Register 0 writes are dropped
        tbl[13] = '{1, 0, 32'hFFFF,     1, 0, 0,  0, 1, 0, 4, 32'h44,       0, 0, 0, 0};
        tbl[14] = '{0, 0, 32'h0,        1, 0, 0,  0, 1, 0, 4, 32'h44,       0, 0, 0, 0};
        // Streaming push with grant high
        tbl[15] = '{1, 10, 32'h100,     1, 11, 12, 1, 1, 0, 4, 32'h44,      0, 0, 0, 0};
        tbl[16] = '{1, 11, 32'h101,     1, 11, 12, 1, 1, 1, 10, 32'h100,    1, 32'h101, 0, 0};
        tbl[17] = '{1, 12, 32'h102,     1, 11, 12, 1, 1, 1, 11, 32'h101,    0, 0, 1, 32'h102};
        tbl[18] = '{0, 0, 32'h0,        1, 11, 12, 0, 1, 1, 12, 32'h102,    0, 0, 0, 0};
        tbl[19] = '{0, 0, 32'h0,        1, 11, 12, 0, 1, 0, 12, 32'h102,    0, 0, 0, 0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 5, 0);
        #12;
        chk("reset rf_we",    32'(rf_we),    32'd0);
        chk("reset rf_wa",    32'(rf_wa),    32'd0);
        chk("reset rf_wd",    rf_wd,         32'd0);
        chk("reset count",    32'(count),    32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset hit1",     32'(hit1),     32'd0);
        chk("reset hd1",      hd1,           32'd0);
        chk("reset hit2",     32'(hit2),     32'd0);
        chk("reset hd2",      hd2,           32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].iv, tbl[i].ia, tbl[i].id, tbl[i].g, tbl[i].r1, tbl[i].r2);
            tick();
            chk($sformatf("v%0d count", i),    32'(count),    32'(tbl[i].cnt));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d rf_we", i),    32'(rf_we),    32'(tbl[i].we));
            chk($sformatf("v%0d rf_wa", i),    32'(rf_wa),    32'(tbl[i].wa));
            chk($sformatf("v%0d rf_wd", i),    rf_wd,         tbl[i].wd);
            chk($sformatf("v%0d hit1", i),     32'(hit1),     32'(tbl[i].h1));
            chk($sformatf("v%0d hd1", i),      hd1,           tbl[i].d1);
            chk($sformatf("v%0d hit2", i),     32'(hit2),     32'(tbl[i].h2));
            chk($sformatf("v%0d hd2", i),      hd2,           tbl[i].d2);
        end

        // Two writes to the same register: newest wins in bypass; drain
        // behaviour depends on whether coalescing is built in.
        drive(1, 7, 32'hA, 0, 7, 0);
        tick();
        chk("same7 a count", 32'(count), 32'd1);
        chk("same7 a hd1",   hd1,        32'hA);
        drive(1, 7, 32'hB, 0, 7, 0);
        tick();
        chk("same7 b count", 32'(count), COAL ? 32'd1 : 32'd2);
        chk("same7 b hit1",  32'(hit1),  32'd1);
        chk("same7 b hd1",   hd1,        32'hB);
        drive(0, 0, 0, 1, 7, 0);
        tick();
        chk("same7 d1 rf_we", 32'(rf_we), 32'd1);
        chk("same7 d1 rf_wa", 32'(rf_wa), 32'd7);
        chk("same7 d1 rf_wd", rf_wd,      COAL ? 32'hB : 32'hA);
        chk("same7 d1 count", 32'(count), COAL ? 32'd0 : 32'd1);
        chk("same7 d1 hit1",  32'(hit1),  COAL ? 32'd0 : 32'd1);
        chk("same7 d1 hd1",   hd1,        COAL ? 32'h0 : 32'hB);
        tick();
        chk("same7 d2 rf_we", 32'(rf_we), COAL ? 32'd0 : 32'd1);
        chk("same7 d2 rf_wd", rf_wd,      32'hB);
        chk("same7 d2 count", 32'(count), 32'd0);
        tick();
        chk("same7 d3 rf_we", 32'(rf_we), 32'd0);

        // Asynchronous reset in the middle of a drain
        drive(1, 1, 32'h1, 0, 2, 0);
        tick();
        drive(1, 2, 32'h2, 0, 2, 0);
        tick();
        drive(1, 3, 32'h3, 0, 2, 0);
        tick();
        drive(0, 0, 0, 1, 2, 0);
        tick();
        chk("mid rf_we", 32'(rf_we), 32'd1);
        chk("mid rf_wa", 32'(rf_wa), 32'd1);
        chk("mid count", 32'(count), 32'd2);
        chk("mid hit1",  32'(hit1),  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst rf_we",    32'(rf_we),    32'd0);
        chk("arst count",    32'(count),    32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd1);
        chk("arst hit1",     32'(hit1),     32'd0);
        chk("arst rf_wa",    32'(rf_wa),    32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post-rst %0d rf_we", k), 32'(rf_we), 32'd0);
            chk($sformatf("post-rst %0d count", k), 32'(count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
